multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Main sequencer for the multicycle RV32I core: one FSM per instruction (fetch, decode, execute, mem, writeback).
//  Drives datapath enables, mux selects and a 2-bit alu_op; alu_op feeds the existing funct-decoding ALU control.
//  Owns the single shared memory port (req/ready handshake) with a watchdog, and traps on illegal opcodes.
// PARAMETERS
//  MEM_TIMEOUT  255  max wait cycles for mem_ready per access; 0 = watchdog disabled
//  CNT_W        32   width of perf counters (MCTRL_PERF_EN only)
// PORTS
//  clk          in   1   core clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  opcode       in   7   IR[6:0]
//  funct3       in   3   IR[14:12]
//  alu_zero     in   1   ALU result == 0
//  mem_ready    in   1   memory completes access this cycle
//  mem_req      out  1   memory access request
//  mem_we       out  1   1 = write, valid with mem_req
//  addr_sel     out  1   0 = PC, 1 = ALUOut as memory address
//  ir_we        out  1   load IR from mem rdata
//  pc_we        out  1   load PC
//  pc_src       out  1   0 = ALU result, 1 = ALUOut register
//  reg_we       out  1   register file write
//  wb_sel       out  2   00 ALUOut, 01 MDR, 10 PC
//  alu_src_a    out  1   0 = PC, 1 = rs1
//  alu_src_b    out  2   00 rs2, 01 const 4, 10 imm
//  alu_op       out  2   00 ADD, 01 SUB (compare), 10 decode funct3/funct7
//  trap         out  1   sticky fault flag; core halted
//  trap_cause   out  2   00 none, 01 illegal opcode, 10 memory timeout
// BEHAVIOUR
//  States: RESET, FETCH, DECODE, EXEC, ALU_WB, ADDR, MEM_RD, LOAD_WB, MEM_WR, BRANCH, JAL, TRAP.
//  Reset: state = RESET; all outputs 0; trap_cause = 00. RESET -> FETCH unconditionally after 1 cycle.
//  Outputs are Moore (decoded from state), except BRANCH pc_we, which also depends on alu_zero/funct3.
//  FETCH: mem_req=1, addr_sel=0, alu_src_a=0, alu_src_b=01, alu_op=00. Hold until mem_ready=1;
//    that cycle: ir_we=1, pc_we=1, pc_src=0 -> DECODE. Minimum fetch latency is 1 cycle.
//  DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target -> ALUOut). Next state by opcode:
//    0110011/0010011 -> EXEC; 0000011/0100011 -> ADDR; 1100011 -> BRANCH; 1101111 -> JAL; else -> TRAP (cause 01).
//  EXEC: alu_src_a=1, alu_src_b = 00 (R) / 10 (I), alu_op=10 -> ALU_WB. ALU_WB: reg_we=1, wb_sel=00 -> FETCH.
//  ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_RD (load) / MEM_WR (store).
//  MEM_RD: mem_req=1, addr_sel=1; on mem_ready -> LOAD_WB. LOAD_WB: reg_we=1, wb_sel=01 -> FETCH.
//  MEM_WR: mem_req=1, mem_we=1, addr_sel=1; on mem_ready -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01; pc_src=1; pc_we = (funct3==000 & zero) | (funct3==001 & !zero);
//    other funct3 not taken; -> FETCH.
//  JAL: reg_we=1, wb_sel=10, pc_we=1, pc_src=1 -> FETCH. A JAL to x0 is discarded by the regfile.
//  Handshake: mem_req, mem_we and addr_sel stay stable from assertion through the cycle mem_ready=1;
//    they drop the next cycle. mem_ready while mem_req=0 is ignored.
//  Watchdog: counts consecutive cycles of mem_req=1 & mem_ready=0; it clears on state change.
//    Reaching MEM_TIMEOUT -> TRAP (cause 10). When mem_ready arrives on the same cycle, ready wins.
//  TRAP: all strobes 0; trap=1; state latched until rst. Reset mid-access drops mem_req asynchronously.
// CONFIGURATION
//  MCTRL_PERF_EN defined: extra outputs perf_cycles[CNT_W] and perf_instret[CNT_W], both reset to 0.
//    cycles increments every non-RESET/TRAP cycle; instret increments on every transition into FETCH
//    from a non-RESET state; both wrap modulo 2^CNT_W.
//  Undefined: those ports and counters are absent; no other behaviour changes.
// STRUCTURE
//  Package mctrl_pkg holds the state enum, RV32I opcode constants, alu_op, wb_sel, alu_src_b and trap_cause encodings.
//  Sub-module mctrl_mem_watchdog: counter + timeout compare, with inputs busy, ready, clear and output expired.
// TESTING
//  ADD (0110011): FETCH ready on 1st cycle -> FETCH,DECODE,EXEC,ALU_WB; reg_we=1 for 1 cycle; alu_op=10 in EXEC.
//  LW, mem_ready delayed 3 cycles -> mem_req held 4 cycles with addr_sel=1, then LOAD_WB with wb_sel=01.
//  BEQ, alu_zero=1 -> pc_we=1, pc_src=1 in BRANCH; BNE, alu_zero=1 -> pc_we=0.
//  opcode 7'b1111111 -> TRAP with trap=1, trap_cause=01; it stays there with mem_req=0 until rst.
//  MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP with cause 10 after 4 wait cycles; ready on the 4th cycle -> no trap.
//  rst asserted mid-MEM_WR -> mem_req/mem_we drop immediately; RESET, then FETCH; perf counters read 0.

Source files
------------

// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control sequencer.
// Holds the state enum, opcode constants and the datapath control encodings.
package mctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_ALU_WB,
    ST_ADDR,
    ST_MEM_RD,
    ST_LOAD_WB,
    ST_MEM_WR,
    ST_BRANCH,
    ST_JAL,
    ST_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Only BEQ/BNE are decoded; every other branch funct3 falls through.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
    return ((f3 == F3_BEQ) && zero) || ((f3 == F3_BNE) && !zero);
  endfunction

endpackage

// File: rtl/mctrl_mem_watchdog.sv
// Memory-access watchdog: counts consecutive stalled request cycles and flags
// expiry on the cycle the limit is reached, unless ready arrives that cycle.
module mctrl_mem_watchdog #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic ready,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear || !busy || ready) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // A zero limit disables expiry; the counter then just free-runs harmlessly.
  assign expired = (MEM_TIMEOUT != 0) && busy && !ready && (count_reg == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I main sequencer: per-instruction FSM, shared memory port and trap.
// Optional perf counters are built when MCTRL_PERF_EN is defined.
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
`ifdef MCTRL_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       trap,
  output logic [1:0] trap_cause
`ifdef MCTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_cycles,
  output logic [CNT_W-1:0] perf_instret
`endif
);

  state_t     state_reg, state_next;
  logic [1:0] cause_reg, cause_next;
  logic       mem_busy;
  logic       wd_expired;

  assign mem_busy = (state_reg == ST_FETCH) || (state_reg == ST_MEM_RD) ||
                    (state_reg == ST_MEM_WR);

  mctrl_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .busy    (mem_busy),
    .ready   (mem_ready),
    .clear   (state_next != state_reg),
    .expired (wd_expired)
  );

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    case (state_reg)
      ST_RESET:   state_next = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) begin
          state_next = ST_DECODE;
        end else if (wd_expired) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_R, OP_I:        state_next = ST_EXEC;
          OP_LOAD, OP_STORE: state_next = ST_ADDR;
          OP_BRANCH:         state_next = ST_BRANCH;
          OP_JAL:            state_next = ST_JAL;
          default: begin
            state_next = ST_TRAP;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_EXEC:    state_next = ST_ALU_WB;
      ST_ALU_WB:  state_next = ST_FETCH;
      ST_ADDR:    state_next = (opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ready) begin
          state_next = ST_LOAD_WB;
        end else if (wd_expired) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_LOAD_WB: state_next = ST_FETCH;
      ST_MEM_WR: begin
        if (mem_ready) begin
          state_next = ST_FETCH;
        end else if (wd_expired) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_BRANCH:  state_next = ST_FETCH;
      ST_JAL:     state_next = ST_FETCH;
      ST_TRAP:    state_next = ST_TRAP;
      default:    state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_RESET;
      cause_reg <= CAUSE_NONE;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
    end
  end

  // Outputs decode straight from the state register so reset clears them at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = WB_ALUOUT;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RS2;
    alu_op    = ALU_ADD;
    case (state_reg)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      ST_DECODE:  alu_src_b = SRCB_IMM;
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = (opcode == OP_R) ? SRCB_RS2 : SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      ST_ALU_WB:  reg_we = 1'b1;
      ST_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
      end
      ST_LOAD_WB: begin
        reg_we = 1'b1;
        wb_sel = WB_MDR;
      end
      ST_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 1'b1;
        pc_we     = branch_taken(funct3, alu_zero);
      end
      ST_JAL: begin
        reg_we = 1'b1;
        wb_sel = WB_PC;
        pc_we  = 1'b1;
        pc_src = 1'b1;
      end
      default: ;
    endcase
  end

  assign trap       = (state_reg == ST_TRAP);
  assign trap_cause = cause_reg;

`ifdef MCTRL_PERF_EN
  logic [CNT_W-1:0] cycles_reg, instret_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_reg  <= '0;
      instret_reg <= '0;
    end else begin
      if (state_reg != ST_RESET && state_reg != ST_TRAP)
        cycles_reg <= cycles_reg + 1'b1;
      if (state_next == ST_FETCH && state_reg != ST_FETCH && state_reg != ST_RESET)
        instret_reg <= instret_reg + 1'b1;
    end
  end

  assign perf_cycles  = cycles_reg;
  assign perf_instret = instret_reg;
`endif

endmodule
